// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue arbiter.
// Optional statistics outputs are enabled by defining PQ_ARB_STATS_EN.
package pq_pkg;

    localparam int unsigned KV_W        = 16;
    localparam int unsigned TMR_W       = 8;
    localparam int unsigned STAT_W      = 8;
    localparam int unsigned ARB_TIMEOUT = 255;

    typedef logic [KV_W-1:0] kv_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_ENQ,
        OP_DEQ,
        OP_BAD
    } op_t;

    // Saturating increment used by the statistics counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/arb_timer.sv
// WAIT-state watchdog: counts enabled cycles up to ARB_TIMEOUT and flags expiry.
module arb_timer
    import pq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [TMR_W-1:0] count_q, count_d;
    logic             expired_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != TMR_W'(ARB_TIMEOUT))) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == TMR_W'(ARB_TIMEOUT));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/pq_arbiter.sv
// Round-robin arbiter granting two requesters single-operation access to a priority queue.
// Define PQ_ARB_STATS_EN to add the r0_ops/r1_ops/err_cnt statistics outputs.
module pq_arbiter
    import pq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic r0_enq,
    input  logic r1_enq,
    input  logic r0_deq,
    input  logic r1_deq,
    input  kv_t  r0_kvi,
    input  kv_t  r1_kvi,
    output logic r0_ack,
    output logic r1_ack,
    output logic r0_err,
    output logic r1_err,
    output kv_t  r0_kvo,
    output kv_t  r1_kvo,
    output logic pq_enq,
    output logic pq_deq,
    output kv_t  pq_kvi,
    input  kv_t  pq_kvo,
    input  logic pq_full,
    input  logic pq_busy,
    input  logic pq_empty
`ifdef PQ_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] r0_ops,
    output logic [STAT_W-1:0] r1_ops,
    output logic [STAT_W-1:0] err_cnt
`endif
);

    arb_state_t state_q, state_d;
    op_t        op_q, op_d;
    logic       rr_q, rr_d;
    logic       gnt_q, gnt_d;
    logic       resp_err_q, resp_err_d;
    kv_t        kv_q, kv_d;
    kv_t        rdata_q, rdata_d;
    kv_t        pq_kvi_q, pq_kvi_d;
    logic       pq_enq_q, pq_enq_d;
    logic       pq_deq_q, pq_deq_d;
    logic [1:0] ack_q, ack_d;
    logic [1:0] err_q, err_d;
    kv_t [1:0]  kvo_q, kvo_d;

    logic [1:0] req_enq_c, req_deq_c, pend_c;
    logic       win_c;
    logic       tmr_clr_c, tmr_en_c, tmr_exp;

    // A requester whose response is visible this cycle is not re-granted on a stale level
    assign req_enq_c = {r1_enq, r0_enq};
    assign req_deq_c = {r1_deq, r0_deq};
    assign pend_c    = (req_enq_c | req_deq_c) & ~(ack_q | err_q);
    assign win_c     = pend_c[rr_q] ? rr_q : ~rr_q;

    arb_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clr_c),
        .enable_i  (tmr_en_c),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        resp_err_d = resp_err_q;
        kv_d       = kv_q;
        rdata_d    = rdata_q;
        pq_kvi_d   = pq_kvi_q;
        kvo_d      = kvo_q;
        pq_enq_d   = 1'b0;
        pq_deq_d   = 1'b0;
        ack_d      = 2'b00;
        err_d      = 2'b00;
        tmr_clr_c  = 1'b1;
        tmr_en_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!pq_busy && (|pend_c)) begin
                    gnt_d = win_c;
                    rr_d  = ~win_c;
                    kv_d  = win_c ? r1_kvi : r0_kvi;
                    if (req_enq_c[win_c] && req_deq_c[win_c]) begin
                        op_d = OP_BAD;
                    end else if (req_enq_c[win_c]) begin
                        op_d = OP_ENQ;
                    end else begin
                        op_d = OP_DEQ;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                resp_err_d = 1'b0;
                case (op_q)
                    OP_ENQ: begin
                        if (pq_full) begin
                            resp_err_d = 1'b1;
                            state_d    = RESP;
                        end else begin
                            pq_enq_d = 1'b1;
                            pq_kvi_d = kv_q;
                            state_d  = WAIT;
                        end
                    end
                    OP_DEQ: begin
                        if (pq_empty) begin
                            resp_err_d = 1'b1;
                            state_d    = RESP;
                        end else begin
                            pq_deq_d = 1'b1;
                            rdata_d  = pq_kvo;
                            state_d  = WAIT;
                        end
                    end
                    default: begin
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end
                endcase
            end
            WAIT: begin
                tmr_clr_c = 1'b0;
                tmr_en_c  = 1'b1;
                if (!pq_busy) begin
                    state_d = RESP;
                end else if (tmr_exp) begin
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                ack_d[gnt_q] = ~resp_err_q;
                err_d[gnt_q] = resp_err_q;
                if (!resp_err_q && (op_q == OP_DEQ)) begin
                    kvo_d[gnt_q] = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_ENQ;
            rr_q       <= 1'b0;
            gnt_q      <= 1'b0;
            resp_err_q <= 1'b0;
            kv_q       <= '0;
            rdata_q    <= '0;
            pq_kvi_q   <= '0;
            pq_enq_q   <= 1'b0;
            pq_deq_q   <= 1'b0;
            ack_q      <= 2'b00;
            err_q      <= 2'b00;
            kvo_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            resp_err_q <= resp_err_d;
            kv_q       <= kv_d;
            rdata_q    <= rdata_d;
            pq_kvi_q   <= pq_kvi_d;
            pq_enq_q   <= pq_enq_d;
            pq_deq_q   <= pq_deq_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            kvo_q      <= kvo_d;
        end
    end

    assign pq_enq = pq_enq_q;
    assign pq_deq = pq_deq_q;
    assign pq_kvi = pq_kvi_q;
    assign r0_ack = ack_q[0];
    assign r1_ack = ack_q[1];
    assign r0_err = err_q[0];
    assign r1_err = err_q[1];
    assign r0_kvo = kvo_q[0];
    assign r1_kvo = kvo_q[1];

`ifdef PQ_ARB_STATS_EN
    logic [1:0][STAT_W-1:0] ops_q, ops_d;
    logic [STAT_W-1:0]      errc_q, errc_d;

    // Counters advance on the same edge that raises the corresponding pulse
    always_comb begin
        ops_d  = ops_q;
        errc_d = errc_q;
        for (int i = 0; i < 2; i++) begin
            if (ack_d[i]) begin
                ops_d[i] = sat_inc(ops_q[i]);
            end
        end
        if (|err_d) begin
            errc_d = sat_inc(errc_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q  <= '0;
            errc_q <= '0;
        end else begin
            ops_q  <= ops_d;
            errc_q <= errc_d;
        end
    end

    assign r0_ops  = ops_q[0];
    assign r1_ops  = ops_q[1];
    assign err_cnt = errc_q;
`endif

endmodule
